// File: rtl/inv_mixcolumns_iter_if.sv
// Handshake bundle for the iterative InvMixColumns unit.
// Input state and result each travel on a valid/ready pair.
interface inv_mixcolumns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out
    );
endinterface

// File: rtl/inv_mixcolumns_iter.sv
// Iterative AES InvMixColumns: one shared column datapath,
// one 32-bit column per clock, registered result held until taken.
module inv_mixcolumns_iter (
    input  logic clk,
    input  logic rst,
    inv_mixcolumns_iter_if.slave io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       col;
    logic [3:0][31:0] work;
    logic [31:0]      col_in;
    logic [31:0]      col_out;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] s  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[31-8*i -: 8];
            x2    = xt(s[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // column 0 sits in the top word, so column c is work[3-c]
    always_comb begin
        col_in  = work[2'd3 - col];
        col_out = inv_col(col_in);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (io.in_valid)  state_nxt = RUN;
            RUN:  if (col == 2'd3)  state_nxt = DONE;
            DONE: if (io.out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // capture the block, then rewrite one column in place per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            col  <= 2'd0;
            work <= '0;
        end else if (state == IDLE && io.in_valid) begin
            col  <= 2'd0;
            work <= io.state_in;
        end else if (state == RUN) begin
            work[2'd3 - col] <= col_out;
            col              <= col + 2'd1;
        end
    end

    // handshake outputs; in_ready is masked during reset
    always_comb begin
        io.in_ready  = (state == IDLE) && !rst;
        io.out_valid = (state == DONE);
        io.state_out = work;
    end

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Self-checking bench for inv_mixcolumns_iter.
// Reference model uses a generic GF(2^8) multiply and matrix form.
module tb_inv_mixcolumns_iter;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    inv_mixcolumns_iter_if io();

    inv_mixcolumns_iter dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // circulant matrix product: coef[(k - r) mod 4] * s[k]
    function automatic logic [127:0] mat_mix(input logic [127:0] s,
                                             input logic [31:0]  coefs);
        logic [127:0] r;
        logic [7:0]   acc;
        logic [7:0]   cf [4];
        for (int i = 0; i < 4; i++) cf[i] = coefs[31-8*i -: 8];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(cf[(k - row + 4) % 4], s[127-32*c-8*k -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_fwd(input logic [127:0] s);
        return mat_mix(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] mix_inv(input logic [127:0] s);
        return mat_mix(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        for (k = 0; k < 20 && !io.in_ready; k++) tick();
        check({tag, "_ready"}, 128'(io.in_ready), 128'(1));
    endtask

    // accept one block, count latency to out_valid, check result, consume
    task automatic run_one(input string tag, input logic [127:0] din,
                           input logic [127:0] exp);
        int lat;
        wait_ready(tag);
        io.state_in = din;
        io.in_valid = 1'b1;
        tick();
        io.in_valid = 1'b0;
        lat = 0;
        while (!io.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(4));
        check({tag, "_data"}, io.state_out, exp);
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
        check({tag, "_vld_clr"}, 128'(io.out_valid), 128'(0));
        check({tag, "_rdy_back"}, 128'(io.in_ready), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] x;
        logic [127:0] held;
        logic [127:0] orig;
        logic [127:0] exp_q [$];
        int           sent;
        int           got;
        int           last;
        int           cyc;
        logic         acc;
        logic         hs;

        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.state_in  = '0;
        io.out_ready = 1'b0;
        tick();
        tick();
        check("rst_vld", 128'(io.out_valid), 128'(0));
        check("rst_out", io.state_out, 128'(0));
        check("rst_rdy", 128'(io.in_ready), 128'(0));
        rst = 1'b0;
        #1;
        check("rst_rdy_rel", 128'(io.in_ready), 128'(1));

        run_one("fips", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                128'hdb135345_f20a225c_01010101_c6c6c6c6);
        run_one("vec2", 128'hd5d5d7d6_4d7ebdf8_ffffffff_00000000,
                128'hd4d4d4d5_2d26314c_ffffffff_00000000);
        for (int i = 0; i < 4; i++) begin
            x = rand128();
            run_one("rand", x, mix_inv(x));
        end

        // back-pressure
        x = rand128();
        wait_ready("bp");
        io.state_in = x;
        io.in_valid = 1'b1;
        tick();
        io.in_valid = 1'b0;
        for (int k = 0; k < 20 && !io.out_valid; k++) tick();
        check("bp_vld", 128'(io.out_valid), 128'(1));
        held = io.state_out;
        check("bp_data", held, mix_inv(x));
        for (int k = 0; k < 10; k++) begin
            io.in_valid = 1'($urandom_range(0, 1));
            io.state_in = rand128();
            tick();
            check("bp_hold_vld", 128'(io.out_valid), 128'(1));
            check("bp_hold_out", io.state_out, held);
            check("bp_hold_rdy", 128'(io.in_ready), 128'(0));
        end
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        tick();
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        check("bp_rel_vld", 128'(io.out_valid), 128'(0));
        check("bp_rel_rdy", 128'(io.in_ready), 128'(1));

        // reset on the second RUN cycle
        wait_ready("mr");
        io.state_in = rand128();
        io.in_valid = 1'b1;
        tick();
        io.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("mr_vld", 128'(io.out_valid), 128'(0));
        check("mr_out", io.state_out, 128'(0));
        rst = 1'b0;
        #1;
        check("mr_rdy", 128'(io.in_ready), 128'(1));
        x = rand128();
        run_one("mr_next", x, mix_inv(x));

        // round trip, streaming
        orig         = rand128();
        io.state_in  = mix_fwd(orig);
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        sent = 0;
        got  = 0;
        last = -1;
        cyc  = 0;
        while (got < 1000 && cyc < 7000) begin
            acc = io.in_ready && io.in_valid;
            hs  = io.out_valid && io.out_ready;
            if (hs) begin
                check("rt_queue", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0)
                    check("rt_data", io.state_out, exp_q.pop_front());
                if (last >= 0)
                    check("rt_gap", 128'(cyc - last), 128'(6));
                last = cyc;
                got++;
            end
            if (acc) exp_q.push_back(orig);
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 1000) begin
                    orig        = rand128();
                    io.state_in = mix_fwd(orig);
                end else begin
                    io.in_valid = 1'b0;
                end
            end
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        check("rt_sent", 128'(sent), 128'(1000));
        check("rt_got", 128'(got), 128'(1000));
        check("rt_left", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
